// File: rtl/rx_axis_pkg.sv
// Shared types and helpers for the rx_axis read controller and its strobe decoder.
package rx_axis_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        XFER    = 2'd2,
        RD_DONE = 2'd3
    } rd_state_e;

    localparam int BYTES_PER_BEAT = 32;
    localparam int LEN_WIDTH      = 14;
    localparam int BEAT_WIDTH     = LEN_WIDTH - 5 + 1;

    // Number of 32-byte beats needed to carry len bytes.
    function automatic logic [BEAT_WIDTH-1:0] ceil_beats(input logic [LEN_WIDTH-1:0] len);
        return {1'b0, len[LEN_WIDTH-1:5]} + {{(BEAT_WIDTH-1){1'b0}}, |len[4:0]};
    endfunction

endpackage

// File: rtl/rx_axis_strb_gen.sv
// Byte-enable decoder: full strobe on body beats, low rem bytes on the last beat.
module rx_axis_strb_gen #(
    parameter int BCNT_WIDTH = 32,
    parameter int REM_WIDTH  = $clog2(BCNT_WIDTH)
) (
    input  logic [REM_WIDTH-1:0]  rem_i,
    input  logic                  last_i,
    output logic [BCNT_WIDTH-1:0] strb_o
);

    // A remainder of zero means the last beat is completely filled.
    always_comb begin
        strb_o = {BCNT_WIDTH{1'b1}};
        if (last_i && (rem_i != {REM_WIDTH{1'b0}})) begin
            for (int i = 0; i < BCNT_WIDTH; i++) begin
                strb_o[i] = (i < int'(rem_i));
            end
        end else begin
            strb_o = {BCNT_WIDTH{1'b1}};
        end
    end

endmodule

// File: rtl/rx_axis_rd_ctrl.sv
// RX read controller: pops descriptors and data beats from show-ahead FIFOs and
// drives the rx_axis_mac AXI4-Stream master with tstrb/tlast/tuser/tbcnt.
module rx_axis_rd_ctrl #(
    parameter int DATA_WIDTH = 256,
    parameter int BCNT_WIDTH = 32,
    parameter int LEN_WIDTH  = 14
) (
    input  logic                  rx_mac_aclk,
    input  logic                  reset_,
    input  logic                  ctrl_en,
    input  logic                  desc_empty,
    input  logic [LEN_WIDTH-1:0]  desc_len,
    input  logic                  desc_err,
    output logic                  desc_rd,
    input  logic                  data_empty,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  data_rd,
    input  logic                  rx_axis_mac_tready,
    output logic                  rx_axis_mac_tvalid,
    output logic [DATA_WIDTH-1:0] rx_axis_mac_tdata,
    output logic [BCNT_WIDTH-1:0] rx_axis_mac_tstrb,
    output logic                  rx_axis_mac_tlast,
    output logic                  rx_axis_mac_tuser,
    output logic [BCNT_WIDTH-1:0] rx_axis_mac_tbcnt,
    output logic                  axis_rd_done_st,
    output logic [31:0]           pkt_cnt,
    output logic [15:0]           drop_cnt
);
    import rx_axis_pkg::*;

    localparam logic [BEAT_WIDTH-1:0] ONE_BEAT = BEAT_WIDTH'(1);

    rd_state_e              state_q;
    logic [LEN_WIDTH-1:0]   len_q;
    logic                   err_q;
    logic [BEAT_WIDTH-1:0]  beats_q;
    logic [31:0]            pkt_cnt_q;
    logic [15:0]            drop_cnt_q;

    logic                   in_xfer_s;
    logic                   tlast_s;
    logic                   hs_s;
    logic [BCNT_WIDTH-1:0]  strb_s;

    assign in_xfer_s = (state_q == XFER);
    assign tlast_s   = in_xfer_s && (beats_q == ONE_BEAT);
    assign hs_s      = rx_axis_mac_tvalid && rx_axis_mac_tready;

    rx_axis_strb_gen #(
        .BCNT_WIDTH (BCNT_WIDTH)
    ) u_strb_gen (
        .rem_i  (len_q[4:0]),
        .last_i (tlast_s),
        .strb_o (strb_s)
    );

    // Outputs are decoded from registered state; only data_rd sees tready.
    assign rx_axis_mac_tvalid = in_xfer_s && !data_empty;
    assign rx_axis_mac_tdata  = in_xfer_s ? data_in : {DATA_WIDTH{1'b0}};
    assign rx_axis_mac_tstrb  = in_xfer_s ? strb_s : {BCNT_WIDTH{1'b0}};
    assign rx_axis_mac_tlast  = tlast_s;
    assign rx_axis_mac_tuser  = err_q && tlast_s;
    assign rx_axis_mac_tbcnt  = (state_q == IDLE) ? {BCNT_WIDTH{1'b0}}
                                                  : {{(BCNT_WIDTH-LEN_WIDTH){1'b0}}, len_q};
    assign desc_rd            = (state_q == LOAD);
    assign data_rd            = hs_s;
    assign axis_rd_done_st    = (state_q == RD_DONE);
    assign pkt_cnt            = pkt_cnt_q;
    assign drop_cnt           = drop_cnt_q;

    // Packet sequencer. The descriptor is captured on leaving IDLE: the head
    // entry is show-ahead and cannot change until the LOAD-cycle pop.
    always_ff @(posedge rx_mac_aclk or negedge reset_) begin
        if (!reset_) begin
            state_q    <= IDLE;
            len_q      <= {LEN_WIDTH{1'b0}};
            err_q      <= 1'b0;
            beats_q    <= {BEAT_WIDTH{1'b0}};
            pkt_cnt_q  <= 32'd0;
            drop_cnt_q <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ctrl_en && !desc_empty) begin
                        len_q   <= desc_len;
                        err_q   <= desc_err;
                        state_q <= LOAD;
                    end else begin
                        len_q   <= {LEN_WIDTH{1'b0}};
                        err_q   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (len_q == {LEN_WIDTH{1'b0}}) begin
                        if (drop_cnt_q != 16'hFFFF) begin
                            drop_cnt_q <= drop_cnt_q + 16'd1;
                        end
                        state_q <= IDLE;
                    end else begin
                        beats_q <= ceil_beats(len_q);
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    if (hs_s) begin
                        beats_q <= beats_q - ONE_BEAT;
                        if (beats_q == ONE_BEAT) begin
                            state_q <= RD_DONE;
                        end
                    end
                end
                RD_DONE: begin
                    pkt_cnt_q <= pkt_cnt_q + 32'd1;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_axis_rd_ctrl.sv
// Directed bench for rx_axis_rd_ctrl with a show-ahead FIFO model on both inputs.
module tb_rx_axis_rd_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ctrl_en = 1'b0;
    logic         desc_empty = 1'b1;
    logic [13:0]  desc_len = 14'd0;
    logic         desc_err = 1'b0;
    logic         desc_rd;
    logic         data_empty = 1'b1;
    logic [255:0] data_in = 256'd0;
    logic         data_rd;
    logic         tready = 1'b0;
    logic         tvalid;
    logic [255:0] tdata;
    logic [31:0]  tstrb;
    logic         tlast;
    logic         tuser;
    logic [31:0]  tbcnt;
    logic         done;
    logic [31:0]  pkt_cnt;
    logic [15:0]  drop_cnt;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int exp_pkt = 0;
    int exp_drop = 0;

    always #5 clk = ~clk;

    rx_axis_rd_ctrl dut (
        .rx_mac_aclk        (clk),
        .reset_             (rst_n),
        .ctrl_en            (ctrl_en),
        .desc_empty         (desc_empty),
        .desc_len           (desc_len),
        .desc_err           (desc_err),
        .desc_rd            (desc_rd),
        .data_empty         (data_empty),
        .data_in            (data_in),
        .data_rd            (data_rd),
        .rx_axis_mac_tready (tready),
        .rx_axis_mac_tvalid (tvalid),
        .rx_axis_mac_tdata  (tdata),
        .rx_axis_mac_tstrb  (tstrb),
        .rx_axis_mac_tlast  (tlast),
        .rx_axis_mac_tuser  (tuser),
        .rx_axis_mac_tbcnt  (tbcnt),
        .axis_rd_done_st    (done),
        .pkt_cnt            (pkt_cnt),
        .drop_cnt           (drop_cnt)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("%s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] pat(input int pk, input int b);
        return {8{pk[15:0], b[15:0]}};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_tvalid"}, tvalid, 1'b0);
        check({tag, "_tdata"}, tdata, 256'd0);
        check({tag, "_tstrb"}, tstrb, 32'd0);
        check({tag, "_tlast"}, tlast, 1'b0);
        check({tag, "_tuser"}, tuser, 1'b0);
        check({tag, "_tbcnt"}, tbcnt, 32'd0);
        check({tag, "_desc_rd"}, desc_rd, 1'b0);
        check({tag, "_data_rd"}, data_rd, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_pkt_cnt"}, pkt_cnt, 32'd0);
        check({tag, "_drop_cnt"}, drop_cnt, 16'd0);
    endtask

    // One packet through the FIFO model; stall adds tready toggling, data gaps
    // and ctrl_en dropped mid-packet; abort_beat >= 0 asserts reset on that beat.
    task automatic send_pkt(input int len, input logic err, input int nbeats,
                            input logic [31:0] last_strb, input bit stall, input int abort_beat);
        int beat = 0, cyc = 0, gap = 0, rd_cnt = 0, done_cnt = 0, drd_cnt = 0;
        bit popped = 0, pop_pend = 0, in_pkt = 0, prev_stall = 0, end_next = 0, finished = 0;
        bit last;
        logic [255:0] prev_data = 256'd0;
        ctrl_en = 1'b1;
        gap = stall ? 1 : 0;
        while (!finished && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (pop_pend) begin
                beat++;
                pop_pend = 0;
                if (stall && beat[0]) gap = 2;
            end
            desc_empty = popped;
            desc_len   = len[13:0];
            desc_err   = err;
            data_empty = (gap > 0) || (beat >= nbeats);
            data_in    = pat(len, beat);
            tready     = stall ? cyc[0] : 1'b1;
            if (gap > 0) gap--;
            #1;
            if (end_next) begin
                check("end_tbcnt", tbcnt, 32'd0);
                check("end_done", done, 1'b0);
                check("end_tvalid", tvalid, 1'b0);
                check("end_pkt_cnt", pkt_cnt, exp_pkt);
                check("end_drop_cnt", drop_cnt, exp_drop);
                check("end_rd_cnt", rd_cnt, nbeats);
                check("end_done_cnt", done_cnt, (nbeats > 0) ? 1 : 0);
                check("end_desc_rd_cnt", drd_cnt, 1);
                finished = 1;
            end else begin
                if (prev_stall) begin
                    check("stall_tvalid", tvalid, 1'b1);
                    check("stall_tdata", tdata, prev_data);
                end
                if (abort_beat >= 0 && beat == abort_beat && tvalid) begin
                    rst_n = 1'b0;
                    #1;
                    check_all_zero("async_rst");
                    exp_pkt  = 0;
                    exp_drop = 0;
                    desc_empty = 1'b1;
                    data_empty = 1'b1;
                    return;
                end
                if (tvalid) begin
                    last = (beat == nbeats - 1);
                    check("tdata", tdata, pat(len, beat));
                    check("tlast", tlast, last);
                    check("tstrb", tstrb, last ? last_strb : 32'hFFFF_FFFF);
                    check("tuser", tuser, err & last);
                    check("data_rd", data_rd, tready);
                    if (data_rd) begin
                        rd_cnt++;
                        pop_pend = 1;
                    end
                end else begin
                    check("data_rd_idle", data_rd, 1'b0);
                end
                if (desc_rd) begin
                    drd_cnt++;
                    popped = 1;
                    in_pkt = 1;
                    if (stall) ctrl_en = 1'b0;
                    if (nbeats == 0) begin
                        exp_drop++;
                        end_next = 1;
                    end
                end
                if (in_pkt) check("tbcnt", tbcnt, len);
                if (done) begin
                    done_cnt++;
                    check("done_pkt_cnt", pkt_cnt, exp_pkt);
                    exp_pkt++;
                    in_pkt   = 0;
                    end_next = 1;
                end
                prev_stall = tvalid && !tready;
                prev_data  = tdata;
            end
        end
        check("pkt_finished", finished, 1'b1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Descriptor waiting but controller disabled: nothing may start.
        desc_empty = 1'b0;
        desc_len   = 14'd64;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("dis_desc_rd", desc_rd, 1'b0);
            check("dis_tbcnt", tbcnt, 32'd0);
        end

        send_pkt(64,  1'b0, 2, 32'hFFFF_FFFF, 1'b0, -1);
        send_pkt(33,  1'b0, 2, 32'h0000_0001, 1'b0, -1);
        send_pkt(1,   1'b0, 1, 32'h0000_0001, 1'b0, -1);
        send_pkt(100, 1'b1, 4, 32'h0000_000F, 1'b0, -1);
        send_pkt(256, 1'b0, 8, 32'hFFFF_FFFF, 1'b1, -1);
        send_pkt(0,   1'b0, 0, 32'hFFFF_FFFF, 1'b0, -1);
        check("pkt_cnt_after_drop", pkt_cnt, 32'd5);
        check("drop_cnt_after_drop", drop_cnt, 16'd1);

        send_pkt(320, 1'b0, 10, 32'hFFFF_FFFF, 1'b0, 2);
        @(negedge clk);
        #1;
        check_all_zero("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_all_zero("post_reset");

        send_pkt(64, 1'b0, 2, 32'hFFFF_FFFF, 1'b0, -1);
        check("pkt_cnt_final", pkt_cnt, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
